// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin / fixed-select channel multiplexer.
package rr_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next channel index after idx, wrapping at n rather than at a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: first set req bit starting at ptr, wrapping at N.
module rr_pick #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  // Scan offsets from farthest to nearest so the nearest requester is the last writer.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (j < N && req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel W-bit mux with fixed or round-robin source selection and a registered output stage.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  select,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  // Handshake: a word moves on an input when in_valid[k] && in_ready[k], and on the
  // output when out_valid && out_ready. in_ready never depends on anything the producer
  // derives from in_ready; at most one in_ready bit is high, only while the output
  // register can load (empty or draining this cycle) and never while reset is held.

  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_chan;
  logic          r_out_valid;
  logic [SW-1:0] r_rr_ptr;

  logic          w_load_en;
  logic [N-1:0]  w_fixed_req;
  logic [N-1:0]  w_pick_req;
  logic [SW-1:0] w_pick_ptr;
  logic          w_pick_valid;
  logic [SW-1:0] w_pick_idx;
  logic          w_gnt;
  logic [W-1:0]  w_sel_data;

  assign w_load_en = !r_out_valid || out_ready;

  // Fixed mode reuses the encoder with a one-hot mask; select values >= N match no bit.
  always_comb begin
    w_fixed_req = '0;
    for (int k = 0; k < N; k++) begin
      w_fixed_req[k] = (select == SW'(k)) && in_valid[k];
    end
  end

  assign w_pick_req = (mode == MODE_RR) ? in_valid : w_fixed_req;
  assign w_pick_ptr = (mode == MODE_RR) ? r_rr_ptr : '0;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req       (w_pick_req),
    .ptr       (w_pick_ptr),
    .gnt_valid (w_pick_valid),
    .gnt_idx   (w_pick_idx)
  );

  assign w_gnt = rst_n && w_load_en && w_pick_valid;

  always_comb begin
    in_ready   = '0;
    w_sel_data = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = w_gnt && (w_pick_idx == SW'(k));
      if (w_pick_idx == SW'(k)) w_sel_data = in_data[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_load_en) begin
      if (w_pick_valid) begin
        r_out_data  <= w_sel_data;
        r_out_chan  <= w_pick_idx;
        r_out_valid <= 1'b1;
        if (mode == MODE_RR) r_rr_ptr <= SW'(wrap_inc(int'(w_pick_idx), N));
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: an 8-channel and a 5-channel instance against a behavioural model.
module tb_rr_arb_mux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- instance A: N=8 ----------------
  logic [63:0] in_data;
  logic [7:0]  in_valid, in_ready;
  logic        mode, out_valid, out_ready;
  logic [2:0]  select, out_chan;
  logic [7:0]  out_data;

  rr_arb_mux #(.W(8), .N(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .select(select), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // ---------------- instance B: N=5 ----------------
  logic [39:0] b_in_data;
  logic [4:0]  b_in_valid, b_in_ready;
  logic        b_mode, b_out_valid, b_out_ready;
  logic [2:0]  b_select, b_out_chan;
  logic [7:0]  b_out_data;

  rr_arb_mux #(.W(8), .N(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mode(b_mode), .select(b_select), .out_data(b_out_data), .out_chan(b_out_chan),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: what the output register holds and where round-robin search starts.
  int         mv[2];
  int         mc[2];
  int         mp[2];
  logic [7:0] md[2];

  function automatic int model_pick(input logic [7:0] v, input int n, input logic m,
                                    input int sel, input int ptr);
    if (!m) return (sel < n && v[sel]) ? sel : -1;
    for (int i = 0; i < n; i++) begin
      if (v[(ptr + i) % n]) return (ptr + i) % n;
    end
    return -1;
  endfunction

  task automatic model_step(input int u, input string tag, input logic rstn,
                            input logic [7:0] v, input logic m, input int sel,
                            input logic ordy, input logic [63:0] dflat, input int n,
                            input logic [7:0] a_ready, input logic a_valid,
                            input logic [7:0] a_data, input int a_chan);
    int g;
    logic ld;
    logic [7:0] exp_rdy;
    if (!rstn) begin
      mv[u] = 0; mc[u] = 0; mp[u] = 0; md[u] = 8'h00;
    end
    check({tag, "_out_valid"}, 64'(a_valid), 64'(mv[u]));
    check({tag, "_out_data"},  64'(a_data),  64'(md[u]));
    check({tag, "_out_chan"},  64'(a_chan),  64'(mc[u]));
    ld = (mv[u] == 0) || ordy;
    g  = (rstn && ld) ? model_pick(v, n, m, sel, mp[u]) : -1;
    exp_rdy = (g >= 0) ? (8'd1 << g) : 8'd0;
    check({tag, "_in_ready"}, 64'(a_ready), 64'(exp_rdy));
    if (rstn && ld) begin
      if (g >= 0) begin
        mv[u] = 1; mc[u] = g; md[u] = dflat[g*8 +: 8];
        if (m) mp[u] = (g + 1) % n;
      end else begin
        mv[u] = 0;
      end
    end
  endtask

  // Inputs only change just after a rising edge, so values seen here are the ones
  // the next rising edge will capture.
  always @(negedge clk) begin
    model_step(0, "a", rst_n, in_valid, mode, int'(select), out_ready, in_data, 8,
               in_ready, out_valid, out_data, int'(out_chan));
    model_step(1, "b", rst_n, {3'b000, b_in_valid}, b_mode, int'(b_select), b_out_ready,
               {24'h0, b_in_data}, 5, {3'b000, b_in_ready}, b_out_valid, b_out_data,
               int'(b_out_chan));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 5; k++) b_in_data[k*8 +: 8] = 8'hA0 + 8'(k);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    in_data = {$urandom(), $urandom()};
    in_valid = 8'($urandom_range(1, 255));
    mode = 1'($urandom_range(0, 1));
    select = 3'($urandom_range(0, 7));
    out_ready = 1'($urandom_range(0, 1));
    b_in_data = {8'($urandom()), $urandom()};
    b_in_valid = 5'($urandom_range(1, 31));
    b_mode = 1'($urandom_range(0, 1));
    b_select = 3'($urandom_range(0, 7));
    b_out_ready = 1'($urandom_range(0, 1));

    // Reset with random inputs: everything idle.
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_chan",  64'(out_chan),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    in_valid = 8'h00; b_in_valid = 5'b00000;
    out_ready = 1'b1; b_out_ready = 1'b1;
    load_data();
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Fixed mode, select 3, all channels valid.
    mode = 1'b0; select = 3'd3; in_valid = 8'hFF;
    #1 check("fix_in_ready", 64'(in_ready), 64'h08);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("fix_out_data",  64'(out_data),  64'h13);
      check("fix_out_chan",  64'(out_chan),  64'd3);
      check("fix_out_valid", 64'(out_valid), 64'd1);
      check("fix_in_ready_run", 64'(in_ready), 64'h08);
    end

    // Round-robin over channels 0,2,5,7 with no bubbles.
    mode = 1'b1; in_valid = 8'b1010_0101;
    exp_q.push_back(8'd0); exp_q.push_back(8'd2); exp_q.push_back(8'd5);
    exp_q.push_back(8'd7); exp_q.push_back(8'd0); exp_q.push_back(8'd2);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      tick();
      e = exp_q.pop_front();
      check("rr_out_chan",  64'(out_chan),  64'(e));
      check("rr_out_valid", 64'(out_valid), 64'd1);
    end

    // Backpressure with a channel 4 word held; pointer sits at 5 afterwards.
    in_valid = 8'h10;
    tick();
    check("bp_load_chan", 64'(out_chan), 64'd4);
    out_ready = 1'b0; in_valid = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      #1 check("bp_in_ready", 64'(in_ready), 64'h00);
      tick();
      check("bp_out_chan", 64'(out_chan), 64'd4);
      check("bp_out_data", 64'(out_data), 64'h14);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 64'(in_ready), 64'h20);
    tick();
    check("bp_next_chan", 64'(out_chan), 64'd5);
    check("bp_next_data", 64'(out_data), 64'h15);

    // N=5: out-of-range select, then wrap of the pointer at 5.
    b_mode = 1'b0; b_select = 3'd6; b_in_valid = 5'b11111;
    #1 check("b_sel6_ready", 64'(b_in_ready), 64'h0);
    tick();
    check("b_sel6_valid", 64'(b_out_valid), 64'd0);
    b_mode = 1'b1; b_in_valid = 5'b10000;
    tick();
    check("b_ch4", 64'(b_out_chan), 64'd4);
    b_in_valid = 5'b00001;
    tick();
    check("b_ch0", 64'(b_out_chan), 64'd0);
    check("b_ch0_data", 64'(b_out_data), 64'hA0);
    b_in_valid = 5'b01000;
    tick();
    check("b_ch3", 64'(b_out_chan), 64'd3);
    b_in_valid = 5'b11001;
    tick();
    check("b_seq_4", 64'(b_out_chan), 64'd4);
    tick();
    check("b_seq_0", 64'(b_out_chan), 64'd0);
    tick();
    check("b_seq_3", 64'(b_out_chan), 64'd3);

    // Asynchronous reset mid-stream; the pointer restarts at channel 0.
    tick();
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("ar_first_ready", 64'(in_ready), 64'h01);
    tick();
    check("ar_first_chan", 64'(out_chan), 64'd0);
    check("ar_first_data", 64'(out_data), 64'h10);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, W-bit multiplexer with per-channel valid/ready handshake and a registered output stage.
- Two modes: fixed (software select picks the channel) and round-robin (fair arbitration among valid channels).
- Serves as the source-selection stage in front of the ALU datapath when several producers share one operand bus.
- Sustains one transfer per cycle with a 1-cycle latency.

Parameters:
- W, 8, data width per channel
- N, 8, number of input channels (>=2; need not be a power of two)
- SW, $clog2(N), width of select / channel index (derived; not overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N*W  flattened channel data; channel k occupies bits [k*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; at most one bit high per cycle
- mode  input  1  0 = fixed select, 1 = round-robin
- select  input  SW  channel index used in fixed mode
- out_data  output  W  registered selected data
- out_chan  output  SW  index of the channel that produced out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  downstream accepts when high with out_valid

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
  - in_ready is combinational, so it is 0 while out_valid=0 and no grant is made.
- Load enable: load_en = !out_valid || out_ready. This is a single-entry pipeline register, so full throughput is maintained when out_ready is held high.
- Pick (combinational, evaluated only when load_en=1):
  - mode=0: grant = select, if select < N and in_valid[select]=1. Otherwise no grant.
  - mode=1: grant = first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1.
- Grant handshake: on a grant g, in_ready[g]=1 and all other in_ready bits are 0. When load_en=0, every in_ready bit is 0.
  - in_ready may depend on in_valid and out_ready.
  - in_valid must never depend on in_ready (producer rule).
- Register update on the clock edge:
  - load_en=1 with a grant: out_data <= channel g data, out_chan <= g, out_valid <= 1.
  - load_en=1 with no grant: out_valid <= 0. out_data and out_chan hold their previous values.
  - load_en=0: all output registers hold (stall). Downstream sees stable out_data and out_chan while out_valid && !out_ready.
- Round-robin pointer:
  - Updates only on a grant made in mode=1: rr_ptr <= (g==N-1) ? 0 : g+1.
  - Wraps at N, not at 2^SW.
  - Holds in mode=0 and when there is no grant.
- Latency: an input accepted in cycle t appears on out_data in cycle t+1.
- Boundary cases:
  - All in_valid=0 and load_en=1: out_valid drops to 0 next cycle, and no in_ready is asserted.
  - select >= N (N not a power of two): treated as no grant. Never an X, never an alias.
  - Mode or select change mid-stream: takes effect at the next load_en cycle. A word already in the output register is unaffected.
  - Simultaneous out_ready and a new grant: the old word leaves and the new word loads in the same edge, with no bubble.
  - rst_n asserted mid-transfer: the word in flight is discarded and out_valid=0 immediately (asynchronous). rr_ptr returns to 0.
- Arithmetic: pure selection, no width conversion. out_data is exactly W bits of the chosen slice.

Decomposition:
- Shared package (rr_arb_pkg):
  - MODE_FIXED=1'b0, MODE_RR=1'b1
  - helper function for the wrapped increment of the channel index
- Sub-module rr_pick: purely combinational rotating-priority encoder.
  - Inputs: req[N-1:0], ptr[SW-1:0].
  - Outputs: gnt_valid, gnt_idx[SW-1:0].
  - Reused by the fixed-mode path with a one-hot request mask.
- Top level holds the load_en logic, the output register, and rr_ptr.

Test Plan:
- Reset: drive rst_n=0 with all inputs random -> out_valid=0, out_data=0, out_chan=0, in_ready=0; after release with in_valid=0, outputs stay idle.
- Fixed mode: mode=0, select=3, in_valid=8'hFF, channel k data = 8'h10+k, out_ready=1 -> every cycle in_ready=8'h08, and one cycle later out_data=8'h13, out_chan=3, out_valid=1.
- Round-robin fairness: mode=1, in_valid=8'b1010_0101, out_ready=1 -> out_chan sequence 0,2,5,7,0,2… with one grant per cycle and no bubbles.
- Backpressure: mode=1, word on channel 4 loaded, out_ready=0 for 3 cycles -> out_data and out_chan stable, in_ready=0 throughout, rr_ptr unchanged; on out_ready=1 the next grant loads in the same edge.
- Non-power-of-two wrap: N=5, mode=0 with select=6 -> no grant and out_valid=0; mode=1 with only in_valid[4]=1 then only in_valid[0]=1 -> rr_ptr wraps 4->0, not 4->5.
- Asynchronous reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> out_valid falls without waiting for clk; after release, the first round-robin grant starts from channel 0.
